// File: rtl/gteq8.sv
// Registered 8-bit magnitude comparator reporting a>=b, a==b and a>b.
// Latency: one clock from the in_valid edge to the result; one compare per cycle.
// Backpressure: none; results are produced unconditionally and held until the next qualified compare.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears all outputs immediately
//   a, b       8-bit operands, sampled on the edge where in_valid=1 (not registered)
//   in_valid   operands qualified this cycle
//   agteqb     registered a >= b
//   aeqb       registered a == b
//   agtb       registered a > b
//   out_valid  result registers were updated by the previous edge
//
// Build option: define GTEQ8_SIGNED_EN to compare the operands as two's complement
// (only the MSB cell changes). Default is an unsigned compare.

// Single bit slice of the comparator: local equality and local "a wins" terms.
module gteq8_cell #(
    parameter bit SIGN_BIT = 1'b0
) (
    input  logic i_a,
    input  logic i_b,
    output logic o_e,
    output logic o_g
);

    assign o_e = ~(i_a ^ i_b);

    // In a two's-complement sign bit a 0 beats a 1, so the "greater" sense inverts.
    generate
        if (SIGN_BIT) begin : g_sign
            assign o_g = ~i_a & i_b;
        end else begin : g_mag
            assign o_g = i_a & ~i_b;
        end
    endgenerate

endmodule

module gteq8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       in_valid,
    output logic       agteqb,
    output logic       aeqb,
    output logic       agtb,
    output logic       out_valid
);

`ifdef GTEQ8_SIGNED_EN
    localparam bit MSB_SIGNED = 1'b1;
`else
    localparam bit MSB_SIGNED = 1'b0;
`endif

    logic [7:0] w_e;
    logic [7:0] w_g;

    // Prefix chains from the MSB down: w_eq_pfx[i] says bits 7..i are all equal,
    // w_gt_pfx[i] says a is already decided greater within bits 7..i.
    logic [8:0] w_eq_pfx;
    logic [8:0] w_gt_pfx;

    logic       w_eq;
    logic       w_gt;
    logic       w_ge;

    logic       r_agteqb;
    logic       r_aeqb;
    logic       r_agtb;
    logic       r_out_valid;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cells
            gteq8_cell #(
                .SIGN_BIT ((gi == 7) ? MSB_SIGNED : 1'b0)
            ) u_cell (
                .i_a (a[gi]),
                .i_b (b[gi]),
                .o_e (w_e[gi]),
                .o_g (w_g[gi])
            );
        end
    endgenerate

    // Ripple: a lower bit only decides the outcome when every bit above it matched.
    always_comb begin
        w_eq_pfx    = '0;
        w_gt_pfx    = '0;
        w_eq_pfx[8] = 1'b1;
        w_gt_pfx[8] = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            w_eq_pfx[i] = w_eq_pfx[i+1] & w_e[i];
            w_gt_pfx[i] = w_gt_pfx[i+1] | (w_eq_pfx[i+1] & w_g[i]);
        end
    end

    assign w_eq = w_eq_pfx[0];
    assign w_gt = w_gt_pfx[0];
    assign w_ge = w_gt | w_eq;

    // Result registers only move on qualified cycles; out_valid tracks in_valid every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_agteqb    <= 1'b0;
            r_aeqb      <= 1'b0;
            r_agtb      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_agteqb <= w_ge;
                r_aeqb   <= w_eq;
                r_agtb   <= w_gt;
            end
        end
    end

    assign agteqb    = r_agteqb;
    assign aeqb      = r_aeqb;
    assign agtb      = r_agtb;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_gteq8.sv
// Testbench for gteq8: directed, hold, exhaustive and async-reset checks with a result queue.
// Latency expected: one clock; expected results are queued on drive and popped on out_valid.
// Backpressure: not applicable; the bench streams one compare per cycle.
module tb_gteq8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a = 8'hAA;
    logic [7:0] b = 8'hAA;
    logic       in_valid = 1'b0;
    logic       agteqb;
    logic       aeqb;
    logic       agtb;
    logic       out_valid;

    typedef struct packed {
        logic ge;
        logic eq;
        logic gt;
    } res_t;

    res_t       exp_q[$];
    res_t       held;
    logic [7:0] last_a;
    logic [7:0] last_b;
    int         n_cmp = 0;
    int         n_err = 0;

    gteq8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .agteqb    (agteqb),
        .aeqb      (aeqb),
        .agtb      (agtb),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference built from native comparison operators, independent of the bit-cell ripple.
    function automatic res_t model(input logic [7:0] x, input logic [7:0] y);
        res_t r;
`ifdef GTEQ8_SIGNED_EN
        r.ge = ($signed(x) >= $signed(y));
        r.gt = ($signed(x) >  $signed(y));
`else
        r.ge = (x >= y);
        r.gt = (x >  y);
`endif
        r.eq = (x == y);
        return r;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s a=%02h b=%02h observed=%b expected=%b", tag, last_a, last_b, obs, expv);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_agteqb"}, agteqb, 1'b0);
        chk({tag, "_aeqb"}, aeqb, 1'b0);
        chk({tag, "_agtb"}, agtb, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
    endtask

    // One clock: drive operands, push the expectation, then check just after the edge.
    task automatic cyc(input logic [7:0] na, input logic [7:0] nb, input logic nv);
        a        = na;
        b        = nb;
        in_valid = nv;
        last_a   = na;
        last_b   = nb;
        if (nv) exp_q.push_back(model(na, nb));
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, nv);
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("queue_underflow", 1'b1, 1'b0);
            end else begin
                held = exp_q.pop_front();
            end
        end
        chk("agteqb", agteqb, held.ge);
        chk("aeqb", aeqb, held.eq);
        chk("agtb", agtb, held.gt);
        chk("ge_is_gt_or_eq", agteqb, agtb | aeqb);
        chk("eq_gt_exclusive", aeqb & agtb, 1'b0);
    endtask

    initial begin
        held   = '0;
        last_a = 8'hAA;
        last_b = 8'hAA;

        // Reset asserted before any clock edge: outputs already at reset values.
        #3;
        chk_reset_state("reset");
        #4;
        rst_n = 1'b1;

        // First qualified compare after release.
        cyc(8'hAA, 8'hAA, 1'b1);

`ifdef GTEQ8_SIGNED_EN
        cyc(8'h00, 8'hFF, 1'b1);
        cyc(8'h80, 8'h7F, 1'b1);
        cyc(8'hFF, 8'h80, 1'b1);
        cyc(8'h80, 8'h80, 1'b1);
        cyc(8'h7F, 8'h80, 1'b1);
        cyc(8'hFE, 8'hFF, 1'b1);
`else
        cyc(8'hCC, 8'hBC, 1'b1);
        cyc(8'h0C, 8'h0D, 1'b1);
        cyc(8'h57, 8'h56, 1'b1);
        cyc(8'h03, 8'h04, 1'b1);
        cyc(8'hFF, 8'h00, 1'b1);
        cyc(8'h00, 8'hFF, 1'b1);
        cyc(8'h69, 8'h68, 1'b1);
`endif
        cyc(8'h00, 8'h00, 1'b1);
        cyc(8'hFF, 8'hFF, 1'b1);

        // Hold: unqualified cycles with changing operands leave results untouched.
        cyc(8'hCC, 8'hBC, 1'b1);
        for (int k = 0; k < 3; k++) cyc(8'h00, 8'hFF, 1'b0);

        // Exhaustive stream with an asynchronous reset dropped in mid-run.
        for (int i = 0; i < 65536; i++) begin
            if (i == 40000) begin
                // A pending qualified compare is discarded by the reset.
                a        = 8'h12;
                b        = 8'h10;
                in_valid = 1'b1;
                last_a   = 8'h12;
                last_b   = 8'h10;
                exp_q.push_back(model(8'h12, 8'h10));
                #2;
                rst_n = 1'b0;
                #1;
                chk_reset_state("async_reset");
                exp_q.delete();
                held = '0;
                @(posedge clk);
                #1;
                chk_reset_state("reset_held");
                #2;
                rst_n = 1'b1;
            end
            cyc(i[15:8], i[7:0], 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
